// File: rtl/ras_pkg.sv
// ras_pkg -- shared definitions for the return-address-stack sequencer.
//   RAS_AW      : return-address width
//   RAS_DEPTH   : number of entries in the attached return-address stack
//   ras_state_e : sequencer states
package ras_pkg;

   localparam int RAS_AW    = 12;
   localparam int RAS_DEPTH = 8;

   typedef enum logic [2:0] {
      FLUSH = 3'd0,
      IDLE  = 3'd1,
      CALL  = 3'd2,
      POP   = 3'd3,
      READ  = 3'd4,
      REJ   = 3'd5
   } ras_state_e;

endpackage

// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if -- call/return request handshake between the main control unit
// and the return-address-stack sequencer.
//   call_req  : call request, held until ack
//   ret_req   : return request, held until ack
//   call_addr : return address to save with a call
//   ack       : one-cycle completion pulse
//   err       : request rejected (valid with ack)
//   busy      : sequencer not idle
// Modports: master = control unit, slave = sequencer.
interface ras_ctrl_if
   import ras_pkg::*;
#(
   parameter int AW = RAS_AW
);

   logic          call_req;
   logic          ret_req;
   logic [AW-1:0] call_addr;
   logic          ack;
   logic          err;
   logic          busy;

   modport master (
      output call_req,
      output ret_req,
      output call_addr,
      input  ack,
      input  err,
      input  busy
   );

   modport slave (
      input  call_req,
      input  ret_req,
      input  call_addr,
      output ack,
      output err,
      output busy
   );

endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl -- sequencer for an external return-address stack.
// Services call (push) and return (pop, then read) requests, tracks the live
// entry count with sticky overflow/underflow flags, and after reset pops the
// stack until its non-resettable pointer is back at zero.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   cu        : request handshake (slave side)
//   stk_push  : stack push strobe      stk_pop  : stack pop strobe
//   stk_addr  : address to push        stk_top  : entry at the stack pointer
//   ret_addr  : popped return address  pc_sel   : ret_addr selects next PC
//   depth     : live entry count
//   ovf, unf  : sticky overflow / underflow flags, cleared by err_clr
module ras_ctrl
   import ras_pkg::*;
#(
   parameter int AW    = RAS_AW,
   parameter int DEPTH = RAS_DEPTH,
   parameter int PW    = $clog2(DEPTH),
   parameter int DW    = $clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst,
   ras_ctrl_if.slave     cu,
   output logic          stk_push,
   output logic          stk_pop,
   output logic [AW-1:0] stk_addr,
   input  logic [AW-1:0] stk_top,
   output logic [AW-1:0] ret_addr,
   output logic          pc_sel,
   output logic [DW-1:0] depth,
   output logic          ovf,
   output logic          unf,
   input  logic          err_clr
);

   localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
   localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   ras_state_e    state_q, state_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] depth_q, depth_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          set_ovf, set_unf;

   // Shadow of the stack's own pointer. The stack pointer is not reset, so
   // this copy is not either; the initializer models the power-up value.
   logic [PW-1:0] ptr_sh_q = '0;
   logic [PW-1:0] ptr_sh_d;

   // Output decode from the registered state only (no req-to-ack path)
   always_comb begin
      cu.ack   = 1'b0;
      cu.err   = 1'b0;
      cu.busy  = 1'b1;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      stk_addr = '0;
      ret_addr = '0;
      pc_sel   = 1'b0;
      case (state_q)
         // pop is gated so a zero pointer never wraps to DEPTH-1
         FLUSH: stk_pop = (ptr_sh_q != '0);
         IDLE:  cu.busy = 1'b0;
         CALL: begin
            stk_push = 1'b1;
            stk_addr = a_q;
            cu.ack   = 1'b1;
         end
         POP:   stk_pop = 1'b1;
         READ: begin
            ret_addr = stk_top;
            pc_sel   = 1'b1;
            cu.ack   = 1'b1;
         end
         REJ: begin
            cu.ack = 1'b1;
            cu.err = 1'b1;
         end
         default: cu.busy = 1'b1;
      endcase
   end

   // Shadow pointer follows every push/pop seen by the stack, even during rst
   always_comb begin
      if (stk_push) begin
         ptr_sh_d = ptr_sh_q + PTR_ONE;
      end else if (stk_pop) begin
         ptr_sh_d = ptr_sh_q - PTR_ONE;
      end else begin
         ptr_sh_d = ptr_sh_q;
      end
   end

   // Next-state, depth and flag logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      depth_d = depth_q;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      case (state_q)
         // leave as soon as the pop in flight brings the pointer to zero
         FLUSH: begin
            if (ptr_sh_d == '0) begin
               state_d = IDLE;
            end else begin
               state_d = FLUSH;
            end
         end
         // a call outranks a simultaneous return; the return stays pending
         IDLE: begin
            if (cu.call_req) begin
               if (depth_q < DEPTH_FULL) begin
                  state_d = CALL;
                  a_d     = cu.call_addr;
               end else begin
                  state_d = REJ;
                  set_ovf = 1'b1;
               end
            end else if (cu.ret_req) begin
               if (depth_q != '0) begin
                  state_d = POP;
               end else begin
                  state_d = REJ;
                  set_unf = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALL: begin
            state_d = IDLE;
            depth_d = depth_q + DEPTH_ONE;
         end
         POP: begin
            state_d = READ;
            depth_d = depth_q - DEPTH_ONE;
         end
         READ:    state_d = IDLE;
         REJ:     state_d = IDLE;
         default: state_d = FLUSH;
      endcase

      // clearing wins over a same-cycle set
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         ovf_d = ovf_q | set_ovf;
         unf_d = unf_q | set_unf;
      end
   end

   // State register; reset skips FLUSH when the stack is already aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (ptr_sh_d != '0) ? FLUSH : IDLE;
         a_q     <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Shadow pointer register (deliberately outside reset)
   always_ff @(posedge clk) begin
      ptr_sh_q <= ptr_sh_d;
   end

   assign depth = depth_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl -- self-checking bench for ras_ctrl. Holds a behavioural model
// of the external stack (array + free-running pointer) and checks the
// sequencer against a queue-based reference of call/return semantics.
module tb_ras_ctrl;
   import ras_pkg::*;

   localparam int AW    = 12;
   localparam int DEPTH = 8;

   typedef struct {
      int            lat;
      logic          e;
      logic [AW-1:0] ra;
      logic [AW-1:0] sa;
      logic          pc;
      logic          push;
      logic          pop;
      logic          to;
      logic          ov;
      logic          un;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          stk_push, stk_pop;
   logic [AW-1:0] stk_addr, stk_top, ret_addr;
   logic          pc_sel;
   logic [3:0]    depth;
   logic          ovf, unf;
   logic          err_clr;

   int n_tests = 0;
   int n_fail  = 0;

   ras_ctrl_if #(.AW(AW)) cu ();

   ras_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .cu       (cu.slave),
      .stk_push (stk_push),
      .stk_pop  (stk_pop),
      .stk_addr (stk_addr),
      .stk_top  (stk_top),
      .ret_addr (ret_addr),
      .pc_sel   (pc_sel),
      .depth    (depth),
      .ovf      (ovf),
      .unf      (unf),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   // external stack model: non-resettable pointer, output shows mem[sp]
   logic [AW-1:0] mem [DEPTH] = '{default: '0};
   logic [2:0]    sp = 3'd0;
   assign stk_top = mem[sp];

   always @(posedge clk) begin
      if (stk_push) begin
         mem[sp] <= stk_addr;
         sp      <= sp + 3'd1;
      end else if (stk_pop) begin
         sp <= sp - 3'd1;
      end
   end

   // push and pop must never be asserted together
   always @(negedge clk) begin
      if (stk_push === 1'b1 && stk_pop === 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_pop_excl: both high at %0t", $time);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // wait (bounded) for ack starting at a negedge; no checking here
   task automatic wait_ack(output res_t r);
      logic done;
      r = '{lat: 0, e: 1'b0, ra: '0, sa: '0, pc: 1'b0, push: 1'b0, pop: 1'b0,
            to: 1'b0, ov: 1'b0, un: 1'b0};
      done = 1'b0;
      while (!done) begin
         @(posedge clk);
         r.lat++;
         @(negedge clk);
         r.push |= stk_push;
         r.pop  |= stk_pop;
         if (cu.ack === 1'b1) begin
            r.e  = cu.err;
            r.ra = ret_addr;
            r.sa = stk_addr;
            r.pc = pc_sel;
            r.ov = ovf;
            r.un = unf;
            done = 1'b1;
         end else if (r.lat >= 20) begin
            r.to = 1'b1;
            done = 1'b1;
         end
      end
   endtask

   // one complete request; returns at the negedge after the ack cycle
   task automatic transact(input logic c, input logic r, input logic [AW-1:0] a,
                           input logic clr, output res_t res);
      @(negedge clk);
      cu.call_req  = c;
      cu.ret_req   = r;
      cu.call_addr = a;
      err_clr      = clr;
      wait_ack(res);
      cu.call_req = 1'b0;
      cu.ret_req  = 1'b0;
      err_clr     = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      cu.call_req  = 1'b0;
      cu.ret_req   = 1'b0;
      cu.call_addr = '0;
      err_clr      = 1'b0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({cu.ack, cu.err, stk_push, stk_pop, pc_sel} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b want 00000",
                  {cu.ack, cu.err, stk_push, stk_pop, pc_sel});
      end
      n_tests++;
      if (cu.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", cu.busy);
      end
      n_tests++;
      if ({ret_addr, stk_addr} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h/%h want 0/0", ret_addr, stk_addr);
      end
      n_tests++;
      if ({depth, ovf, unf} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_depth_flags: got %0d %b %b want 0 0 0", depth, ovf, unf);
      end
   endtask

   task automatic test_basic();
      res_t r;
      logic [AW-1:0] addrs [2];
      int            exp_lat [4];
      logic [AW-1:0] exp_ra  [4];
      logic [3:0]    exp_dep [4];
      addrs   = '{12'h123, 12'h456};
      exp_lat = '{1, 1, 2, 2};
      exp_ra  = '{12'h000, 12'h000, 12'h456, 12'h123};
      exp_dep = '{4'd1, 4'd2, 4'd1, 4'd0};
      for (int i = 0; i < 4; i++) begin
         if (i < 2) transact(1'b1, 1'b0, addrs[i], 1'b0, r);
         else       transact(1'b0, 1'b1, 12'h000, 1'b0, r);
         n_tests++;
         if (r.to || r.lat != exp_lat[i] || r.e !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_lat[%0d]: got lat %0d err %b to %b want lat %0d err 0",
                     i, r.lat, r.e, r.to, exp_lat[i]);
         end
         if (i < 2) begin
            n_tests++;
            if (r.sa !== addrs[i] || r.push !== 1'b1 || r.pop !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_push[%0d]: got addr %h push %b pop %b want %h 1 0",
                        i, r.sa, r.push, r.pop, addrs[i]);
            end
         end else begin
            n_tests++;
            if (r.ra !== exp_ra[i] || r.pc !== 1'b1 || r.pop !== 1'b1) begin
               n_fail++;
               $display("FAIL basic_ret[%0d]: got addr %h pc %b pop %b want %h 1 1",
                        i, r.ra, r.pc, r.pop, exp_ra[i]);
            end
         end
         n_tests++;
         if (depth !== exp_dep[i]) begin
            n_fail++;
            $display("FAIL basic_depth[%0d]: got %0d want %0d", i, depth, exp_dep[i]);
         end
      end
   endtask

   task automatic test_overflow();
      res_t r;
      logic [AW-1:0] a [8];
      for (int i = 0; i < 8; i++) begin
         a[i] = AW'($urandom_range(0, 4094));
         transact(1'b1, 1'b0, a[i], 1'b0, r);
         n_tests++;
         if (r.to || r.e !== 1'b0 || r.push !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_fill[%0d]: got err %b push %b to %b want 0 1 0",
                     i, r.e, r.push, r.to);
         end
      end
      transact(1'b1, 1'b0, 12'hFFF, 1'b0, r);
      n_tests++;
      if (r.to || r.lat != 1 || r.e !== 1'b1 || r.push !== 1'b0 || r.ov !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_ninth: got lat %0d err %b push %b ovf %b want 1 1 0 1",
                  r.lat, r.e, r.push, r.ov);
      end
      n_tests++;
      if (depth !== 4'd8) begin
         n_fail++;
         $display("FAIL ovf_depth: got %0d want 8", depth);
      end
      for (int i = 7; i >= 0; i--) begin
         transact(1'b0, 1'b1, 12'h000, 1'b0, r);
         n_tests++;
         if (r.to || r.e !== 1'b0 || r.ra !== a[i]) begin
            n_fail++;
            $display("FAIL ovf_drain[%0d]: got %h err %b want %h err 0", i, r.ra, r.e, a[i]);
         end
      end
      n_tests++;
      if (depth !== 4'd0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got depth %0d ovf %b want 0 1", depth, ovf);
      end
   endtask

   task automatic test_underflow();
      res_t r;
      transact(1'b0, 1'b1, 12'h000, 1'b0, r);
      n_tests++;
      if (r.to || r.lat != 1 || r.e !== 1'b1 || r.pop !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_rej: got lat %0d err %b pop %b want 1 1 0", r.lat, r.e, r.pop);
      end
      n_tests++;
      if (r.un !== 1'b1 || r.ra !== 12'h000 || r.pc !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_flag: got unf %b ret %h pc %b want 1 000 0", r.un, r.ra, r.pc);
      end
      transact(1'b0, 1'b1, 12'h000, 1'b1, r);
      n_tests++;
      if (r.e !== 1'b1 || unf !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_clr: got err %b unf %b ovf %b want 1 0 0", r.e, unf, ovf);
      end
   endtask

   task automatic test_simultaneous();
      res_t r;
      transact(1'b1, 1'b0, 12'h111, 1'b0, r);
      transact(1'b1, 1'b0, 12'h222, 1'b0, r);
      @(negedge clk);
      cu.call_req  = 1'b1;
      cu.ret_req   = 1'b1;
      cu.call_addr = 12'h333;
      wait_ack(r);
      cu.call_req = 1'b0;
      n_tests++;
      if (r.to || r.lat != 1 || r.push !== 1'b1 || r.pop !== 1'b0 || r.sa !== 12'h333) begin
         n_fail++;
         $display("FAIL simul_call: got lat %0d push %b pop %b addr %h want 1 1 0 333",
                  r.lat, r.push, r.pop, r.sa);
      end
      wait_ack(r);
      cu.ret_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (r.to || r.e !== 1'b0 || r.ra !== 12'h333 || r.pc !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_ret: got %h err %b pc %b want 333 0 1", r.ra, r.e, r.pc);
      end
      n_tests++;
      if (depth !== 4'd2) begin
         n_fail++;
         $display("FAIL simul_depth: got %0d want 2", depth);
      end
      transact(1'b0, 1'b1, 12'h000, 1'b0, r);
      n_tests++;
      if (r.ra !== 12'h222) begin
         n_fail++;
         $display("FAIL simul_drain0: got %h want 222", r.ra);
      end
      transact(1'b0, 1'b1, 12'h000, 1'b0, r);
      n_tests++;
      if (r.ra !== 12'h111) begin
         n_fail++;
         $display("FAIL simul_drain1: got %h want 111", r.ra);
      end
   endtask

   task automatic test_reset_mid();
      res_t r;
      int   pops, cyc, acks;
      transact(1'b1, 1'b0, 12'h0A1, 1'b0, r);
      transact(1'b1, 1'b0, 12'h0A2, 1'b0, r);
      transact(1'b1, 1'b0, 12'h0A3, 1'b0, r);
      @(negedge clk);
      cu.ret_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (stk_pop !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pop_state: got pop %b want 1", stk_pop);
      end
      rst        = 1'b1;
      cu.ret_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      pops = 0;
      cyc  = 0;
      acks = 0;
      while (cu.busy === 1'b1 && cyc < 20) begin
         pops += int'(stk_pop);
         acks += int'(cu.ack);
         cyc++;
         @(posedge clk);
         @(negedge clk);
      end
      n_tests++;
      if (pops != 2 || cyc != 2 || acks != 0) begin
         n_fail++;
         $display("FAIL rstmid_flush: got pops %0d busy cycles %0d acks %0d want 2 2 0",
                  pops, cyc, acks);
      end
      n_tests++;
      if (depth !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_state: got depth %0d ovf %b unf %b want 0 0 0", depth, ovf, unf);
      end
      transact(1'b1, 1'b0, 12'h0AA, 1'b0, r);
      transact(1'b0, 1'b1, 12'h000, 1'b0, r);
      n_tests++;
      if (r.to || r.e !== 1'b0 || r.ra !== 12'h0AA || depth !== 4'd0) begin
         n_fail++;
         $display("FAIL rstmid_roundtrip: got %h err %b depth %0d want 0aa 0 0",
                  r.ra, r.e, depth);
      end
   endtask

   task automatic test_random();
      res_t          r;
      logic [AW-1:0] q [$];
      logic [AW-1:0] a, exp_ra;
      logic          m_ovf, m_unf, is_call, exp_err;
      int            exp_lat;
      transact(1'b0, 1'b0, 12'h000, 1'b1, r);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      for (int i = 0; i < 90; i++) begin
         // first half leans toward calls, second half toward returns
         is_call = (i < 45) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         a       = AW'($urandom);
         exp_ra  = 12'h000;
         if (is_call) begin
            exp_err = (q.size() >= DEPTH);
            exp_lat = 1;
            if (exp_err) m_ovf = 1'b1;
            else         q.push_back(a);
         end else begin
            exp_err = (q.size() == 0);
            exp_lat = exp_err ? 1 : 2;
            if (exp_err) m_unf = 1'b1;
            else         exp_ra = q.pop_back();
         end
         transact(is_call, !is_call, a, 1'b0, r);
         n_tests++;
         if (r.to || r.lat != exp_lat || r.e !== exp_err) begin
            n_fail++;
            $display("FAIL rand_hs[%0d]: got lat %0d err %b to %b want lat %0d err %b",
                     i, r.lat, r.e, r.to, exp_lat, exp_err);
         end
         n_tests++;
         if (r.ra !== exp_ra) begin
            n_fail++;
            $display("FAIL rand_ret[%0d]: got %h want %h", i, r.ra, exp_ra);
         end
         n_tests++;
         if (depth !== 4'(q.size()) || ovf !== m_ovf || unf !== m_unf) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: got depth %0d ovf %b unf %b want %0d %b %b",
                     i, depth, ovf, unf, q.size(), m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
